// File: rtl/branch_resolve_unit_if.sv
// Per-lane branch feedback channel from execute-stage resolution to the next-PC predictor.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

interface branch_fb_ifc #(
   parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH
);
   logic                  if_prediction_correct;
   logic [ADDR_WIDTH-1:0] new_pc;

   modport out (output if_prediction_correct, output new_pc);
   modport in  (input  if_prediction_correct, input  new_pc);
endinterface

// File: rtl/branch_resolve_unit.sv
// Two-lane branch resolution: computes architectural next PC, flags the oldest
// misprediction, and squashes wrong-path ops until the pipeline flush arrives.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_resolve_unit #(
   parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ext_stall,
   input  logic                  ext_flush,
   input  logic                  i_valid        [2],
   input  logic                  i_is_branch    [2],
   input  logic                  i_is_jal       [2],
   input  logic                  i_is_jalr      [2],
   input  logic [2:0]            i_funct3       [2],
   input  logic [ADDR_WIDTH-1:0] i_pc           [2],
   input  logic [ADDR_WIDTH-1:0] i_imm          [2],
   input  logic [31:0]           i_rs1          [2],
   input  logic [31:0]           i_rs2          [2],
   input  logic [ADDR_WIDTH-1:0] i_pred_next_pc [2],
   branch_fb_ifc.out             o_branch       [2],
   output logic [CNT_WIDTH-1:0]  o_branch_count,
   output logic [CNT_WIDTH-1:0]  o_mispredict_count
);

   typedef enum logic {ST_RUN, ST_SQUASH} state_e;

   state_e                state_q, state_d;
   logic [1:0]            correct_q, correct_d;
   logic [ADDR_WIDTH-1:0] new_pc_q [2];
   logic [ADDR_WIDTH-1:0] new_pc_d [2];
   logic [CNT_WIDTH-1:0]  bcnt_q, bcnt_d;
   logic [CNT_WIDTH-1:0]  mcnt_q, mcnt_d;

   logic                  accept;
   logic [1:0]            live;
   logic [1:0]            mis;
   logic [1:0]            rep;
   logic [1:0]            n_counted;
   logic [ADDR_WIDTH-1:0] actual [2];

   function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [1:0]           b);
      logic [CNT_WIDTH:0] s;
      s = {1'b0, a} + (CNT_WIDTH+1)'(b);
      return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
   endfunction

   assign accept = ~ext_stall & ~ext_flush & (state_q == ST_RUN);

   // Per-lane condition evaluation and next-PC computation
   for (genvar l = 0; l < 2; l++) begin : g_lane
      logic                  cond;
      logic                  taken;
      logic [ADDR_WIDTH-1:0] target;

      always_comb begin
         cond = 1'b0;
         case (i_funct3[l])
            3'b000:  cond = (i_rs1[l] == i_rs2[l]);
            3'b001:  cond = (i_rs1[l] != i_rs2[l]);
            3'b100:  cond = ($signed(i_rs1[l]) <  $signed(i_rs2[l]));
            3'b101:  cond = ($signed(i_rs1[l]) >= $signed(i_rs2[l]));
            3'b110:  cond = (i_rs1[l] <  i_rs2[l]);
            3'b111:  cond = (i_rs1[l] >= i_rs2[l]);
            default: cond = 1'b0;
         endcase
      end

      assign taken  = i_is_jal[l] | i_is_jalr[l] | (i_is_branch[l] & cond);
      assign target = i_is_jalr[l]
                    ? ((ADDR_WIDTH'(i_rs1[l]) + i_imm[l]) & {{(ADDR_WIDTH-1){1'b1}}, 1'b0})
                    : (i_pc[l] + i_imm[l]);
      assign actual[l] = taken ? target : (i_pc[l] + ADDR_WIDTH'(4));
      assign live[l]   = accept & i_valid[l] & $onehot({i_is_branch[l], i_is_jal[l], i_is_jalr[l]});
      assign mis[l]    = live[l] & (actual[l] != i_pred_next_pc[l]);

      assign o_branch[l].if_prediction_correct = correct_q[l];
      assign o_branch[l].new_pc                = new_pc_q[l];
   end

   // Lane 0 is older: its mispredict hides lane 1 entirely
   assign rep       = {mis[1] & ~mis[0], mis[0]};
   assign n_counted = 2'(live[0]) + 2'(live[1] & ~mis[0]);

   always_comb begin
      state_d     = state_q;
      correct_d   = 2'b11;
      new_pc_d[0] = '0;
      new_pc_d[1] = '0;
      bcnt_d      = sat_add(bcnt_q, n_counted);
      mcnt_d      = sat_add(mcnt_q, {1'b0, |rep});

      if (rep[0]) begin
         correct_d[0] = 1'b0;
         new_pc_d[0]  = actual[0];
      end else if (rep[1]) begin
         correct_d[1] = 1'b0;
         new_pc_d[1]  = actual[1];
      end

      case (state_q)
         ST_RUN:    if (|rep)     state_d = ST_SQUASH;
         ST_SQUASH: if (ext_flush) state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         correct_q   <= 2'b11;
         new_pc_q[0] <= '0;
         new_pc_q[1] <= '0;
         bcnt_q      <= '0;
         mcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         correct_q   <= correct_d;
         new_pc_q[0] <= new_pc_d[0];
         new_pc_q[1] <= new_pc_d[1];
         bcnt_q      <= bcnt_d;
         mcnt_q      <= mcnt_d;
      end
   end

   assign o_branch_count     = bcnt_q;
   assign o_mispredict_count = mcnt_q;

endmodule
